// File: rtl/dmac_mc_cmd_gen.sv
// Multi-channel AXI burst command generator: splits per-channel copy jobs into
// matched read/write burst commands, round-robin across channels.
module dmac_mc_cmd_gen #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 16,
  parameter int OUTST_MAX = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
  input  logic [NUM_CH*32-1:0]     ch_len,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     rd_cmd_valid,
  input  logic                     rd_cmd_ready,
  output logic [ADDR_W-1:0]        rd_cmd_addr,
  output logic [7:0]               rd_cmd_len,
  output logic [CH_W-1:0]          rd_cmd_ch,
  output logic                     wr_cmd_valid,
  input  logic                     wr_cmd_ready,
  output logic [ADDR_W-1:0]        wr_cmd_addr,
  output logic [7:0]               wr_cmd_len,
  output logic [CH_W-1:0]          wr_cmd_ch,
  input  logic                     wr_cpl_valid,
  input  logic [CH_W-1:0]          wr_cpl_ch
);

  localparam int BPB       = DATA_W / 8;
  localparam int BPB_LG    = $clog2(BPB);
  localparam int MAX_BYTES = MAX_BURST * BPB;
  localparam int OW        = $clog2(OUTST_MAX + 1);

  localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(BPB - 1);
  localparam logic [31:0]       LEN_ALIGN  = ~32'(BPB - 1);

  typedef enum logic [1:0] {IDLE, ARB, CALC, ISSUE} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   grant_q;
  logic [31:0]       chunk_q;

  logic [ADDR_W-1:0] src_q   [NUM_CH];
  logic [ADDR_W-1:0] dst_q   [NUM_CH];
  logic [31:0]       rem_q   [NUM_CH];
  logic [OW-1:0]     outst_q [NUM_CH];
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] done_q;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] ch_inc;
  logic [NUM_CH-1:0] ch_dec;
  logic              arb_found;
  logic [CH_W-1:0]   arb_idx;
  int                arb_j;
  logic [12:0]       src_room;
  logic [12:0]       dst_room;
  logic [31:0]       chunk;
  logic [7:0]        calc_len;
  logic              issue_fire;

  assign ch_busy = busy_q;
  assign ch_done = done_q;

  // The chunk retires only once both the read and the write command have been taken.
  assign issue_fire = (state_q == ISSUE) &&
                      (!rd_cmd_valid || rd_cmd_ready) &&
                      (!wr_cmd_valid || wr_cmd_ready);

  // NOTE: every variable in an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    elig   = '0;
    ch_inc = '0;
    ch_dec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i]   = busy_q[i] && (rem_q[i] != '0) && (outst_q[i] < OW'(OUTST_MAX));
      ch_inc[i] = issue_fire && (grant_q == CH_W'(i));
      ch_dec[i] = wr_cpl_valid && (wr_cpl_ch == CH_W'(i)) && (outst_q[i] != '0);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_CH.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_j     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_j = int'(rr_ptr_q) + k;
      if (arb_j >= NUM_CH) arb_j = arb_j - NUM_CH;
      if (!arb_found && elig[arb_j]) begin
        arb_found = 1'b1;
        arb_idx   = CH_W'(arb_j);
      end
    end
  end

  // NOTE: blocking assignments here build up a combinational min chain; state elements use <= only.
  always_comb begin
    src_room = 13'h1000 - {1'b0, src_q[grant_q][11:0]};
    dst_room = 13'h1000 - {1'b0, dst_q[grant_q][11:0]};
    chunk    = rem_q[grant_q];
    if (32'(MAX_BYTES) < chunk) chunk = 32'(MAX_BYTES);
    if (32'(src_room) < chunk)  chunk = 32'(src_room);
    if (32'(dst_room) < chunk)  chunk = 32'(dst_room);
    calc_len = 8'((chunk >> BPB_LG) - 32'd1);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      chunk_q      <= '0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= '0;
      rd_cmd_ch    <= '0;
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_len   <= '0;
      wr_cmd_ch    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|elig) state_q <= ARB;
        ARB: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rd_cmd_valid <= 1'b1;
          rd_cmd_addr  <= src_q[grant_q];
          rd_cmd_len   <= calc_len;
          rd_cmd_ch    <= grant_q;
          wr_cmd_valid <= 1'b1;
          wr_cmd_addr  <= dst_q[grant_q];
          wr_cmd_len   <= calc_len;
          wr_cmd_ch    <= grant_q;
          chunk_q      <= chunk;
          state_q      <= ISSUE;
        end
        ISSUE: begin
          if (rd_cmd_valid && rd_cmd_ready) rd_cmd_valid <= 1'b0;
          if (wr_cmd_valid && wr_cmd_ready) wr_cmd_valid <= 1'b0;
          if (issue_fire) begin
            rr_ptr_q <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
            state_q  <= ARB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the per-channel arrays are small control state, so they are reset along with everything else.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      busy_q <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i]   <= '0;
        dst_q[i]   <= '0;
        rem_q[i]   <= '0;
        outst_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done_q[i] <= 1'b0;
        if (!busy_q[i]) begin
          if (ch_start[i]) begin
            busy_q[i] <= 1'b1;
            src_q[i]  <= ch_src[i*ADDR_W +: ADDR_W] & ADDR_ALIGN;
            dst_q[i]  <= ch_dst[i*ADDR_W +: ADDR_W] & ADDR_ALIGN;
            rem_q[i]  <= ch_len[i*32 +: 32] & LEN_ALIGN;
          end
        end else if (rem_q[i] == '0 && outst_q[i] == '0) begin
          busy_q[i] <= 1'b0;
          done_q[i] <= 1'b1;
        end else if (ch_inc[i]) begin
          src_q[i] <= src_q[i] + ADDR_W'(chunk_q);
          dst_q[i] <= dst_q[i] + ADDR_W'(chunk_q);
          rem_q[i] <= rem_q[i] - chunk_q;
        end

        if (ch_inc[i] && !ch_dec[i]) begin
          outst_q[i] <= outst_q[i] + OW'(1);
        end else if (!ch_inc[i] && ch_dec[i]) begin
          outst_q[i] <= outst_q[i] - OW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmac_mc_cmd_gen.sv
// Directed bench for dmac_mc_cmd_gen: logs command handshakes, returns write
// completions on demand and checks against hand-computed values.
module tb_dmac_mc_cmd_gen;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic [3:0]   ch_start = '0;
  logic [127:0] ch_src = '0;
  logic [127:0] ch_dst = '0;
  logic [127:0] ch_len = '0;
  logic [3:0]   ch_busy;
  logic [3:0]   ch_done;
  logic         rd_cmd_valid;
  logic         rd_cmd_ready = 1'b0;
  logic [31:0]  rd_cmd_addr;
  logic [7:0]   rd_cmd_len;
  logic [1:0]   rd_cmd_ch;
  logic         wr_cmd_valid;
  logic         wr_cmd_ready = 1'b0;
  logic [31:0]  wr_cmd_addr;
  logic [7:0]   wr_cmd_len;
  logic [1:0]   wr_cmd_ch;
  logic         wr_cpl_valid = 1'b0;
  logic [1:0]   wr_cpl_ch = '0;

  dmac_mc_cmd_gen dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
    .ch_busy(ch_busy), .ch_done(ch_done),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_ch(rd_cmd_ch),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_cmd_ch(wr_cmd_ch),
    .wr_cpl_valid(wr_cpl_valid), .wr_cpl_ch(wr_cpl_ch)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  ch;
  } cpl_t;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        cpl_auto = 1'b0;
  cpl_t        cpl_q[$];
  logic [31:0] rd_addr_q[$];
  logic [7:0]  rd_len_q[$];
  logic [1:0]  rd_ch_q[$];
  int          rd_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_len_q[$];
  logic [1:0]  wr_ch_q[$];
  int          wr_cyc_q[$];
  int          done_cnt[4];
  int          done_cyc[4];
  int          cpl_cnt = 0;
  int          last_cpl = 0;
  int          stab_err = 0;

  logic        prev_rst = 1'b1;
  logic        prev_rd_v = 1'b0, prev_rd_hs = 1'b0, prev_wr_v = 1'b0, prev_wr_hs = 1'b0;
  logic [41:0] prev_rd_pl = '0, prev_wr_pl = '0;

  always @(posedge ap_clk) cyc = cyc + 1;

  // Completion responder: drives one B-response per cycle when one is due.
  always @(negedge ap_clk) begin
    if (cpl_q.size() != 0 && int'(cpl_q[0].due) <= cyc + 1) begin
      wr_cpl_valid = 1'b1;
      wr_cpl_ch    = cpl_q[0].ch;
      void'(cpl_q.pop_front());
    end else begin
      wr_cpl_valid = 1'b0;
      wr_cpl_ch    = '0;
    end
  end

  // Monitor: samples mid-cycle, everything seen here is consumed at the next rising edge.
  always @(negedge ap_clk) begin
    cpl_t e;
    #2;
    if (!ap_rst) begin
      if (rd_cmd_valid && rd_cmd_ready) begin
        rd_addr_q.push_back(rd_cmd_addr);
        rd_len_q.push_back(rd_cmd_len);
        rd_ch_q.push_back(rd_cmd_ch);
        rd_cyc_q.push_back(cyc + 1);
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        wr_addr_q.push_back(wr_cmd_addr);
        wr_len_q.push_back(wr_cmd_len);
        wr_ch_q.push_back(wr_cmd_ch);
        wr_cyc_q.push_back(cyc + 1);
        if (cpl_auto) begin
          e.due = 32'(cyc + 11);
          e.ch  = wr_cmd_ch;
          cpl_q.push_back(e);
        end
      end
      if (wr_cpl_valid) begin
        cpl_cnt  = cpl_cnt + 1;
        last_cpl = cyc + 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_done[i]) begin
          done_cnt[i] = done_cnt[i] + 1;
          done_cyc[i] = cyc;
        end
      end
      if (!prev_rst) begin
        if (prev_rd_v && !prev_rd_hs &&
            (!rd_cmd_valid || {rd_cmd_addr, rd_cmd_len, rd_cmd_ch} != prev_rd_pl))
          stab_err = stab_err + 1;
        if (prev_wr_v && !prev_wr_hs &&
            (!wr_cmd_valid || {wr_cmd_addr, wr_cmd_len, wr_cmd_ch} != prev_wr_pl))
          stab_err = stab_err + 1;
      end
    end
    prev_rst   = ap_rst;
    prev_rd_v  = rd_cmd_valid;
    prev_rd_hs = rd_cmd_valid && rd_cmd_ready;
    prev_rd_pl = {rd_cmd_addr, rd_cmd_len, rd_cmd_ch};
    prev_wr_v  = wr_cmd_valid;
    prev_wr_hs = wr_cmd_valid && wr_cmd_ready;
    prev_wr_pl = {wr_cmd_addr, wr_cmd_len, wr_cmd_ch};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); rd_len_q.delete(); rd_ch_q.delete(); rd_cyc_q.delete();
    wr_addr_q.delete(); wr_len_q.delete(); wr_ch_q.delete(); wr_cyc_q.delete();
    cpl_q.delete();
    for (int i = 0; i < 4; i++) begin
      done_cnt[i] = 0;
      done_cyc[i] = 0;
    end
    cpl_cnt  = 0;
    last_cpl = 0;
    stab_err = 0;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst   = 1'b1;
    ch_start = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_job(input int ch, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] len);
    ch_src[ch*32 +: 32] = src;
    ch_dst[ch*32 +: 32] = dst;
    ch_len[ch*32 +: 32] = len;
  endtask

  // Pulses ch_start for one cycle; t is the rising edge that samples it.
  task automatic pulse_start(input logic [3:0] mask, output int t);
    @(negedge ap_clk);
    ch_start = mask;
    t = cyc + 1;
    @(negedge ap_clk);
    ch_start = '0;
  endtask

  task automatic wait_done(input int ch, input int max_cyc);
    for (int n = 0; n < max_cyc && done_cnt[ch] == 0; n++) @(negedge ap_clk);
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic wait_rd_valid(input int max_cyc);
    for (int n = 0; n < max_cyc && !rd_cmd_valid; n++) @(negedge ap_clk);
  endtask

  int          t0;
  int          nbad;
  logic [15:0] seq_rd, seq_wr;

  initial begin
    // Reset state
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_logs();
    chk("rst_busy", 64'(ch_busy), 64'h0);
    chk("rst_done", 64'(ch_done), 64'h0);
    chk("rst_rd_valid", 64'(rd_cmd_valid), 64'h0);
    chk("rst_wr_valid", 64'(wr_cmd_valid), 64'h0);
    chk("rst_rd_payload", 64'({rd_cmd_addr, rd_cmd_len, rd_cmd_ch}), 64'h0);
    chk("rst_wr_payload", 64'({wr_cmd_addr, wr_cmd_len, wr_cmd_ch}), 64'h0);

    // Single channel, 16 KB in 512 B bursts
    rd_cmd_ready = 1'b1;
    wr_cmd_ready = 1'b1;
    cpl_auto     = 1'b1;
    set_job(0, 32'h2000_0000, 32'h3000_0000, 32'd16384);
    pulse_start(4'b0001, t0);
    chk("single_busy_after_start", 64'(ch_busy[0]), 64'h1);
    chk("single_valid_early", 64'(rd_cmd_valid), 64'h0);
    repeat (3) @(negedge ap_clk);
    chk("single_valid_t3", 64'(rd_cmd_valid && wr_cmd_valid), 64'h1);
    wait_done(0, 600);
    chk("single_done_cnt", 64'(done_cnt[0]), 64'h1);
    chk("single_rd_cnt", 64'(rd_addr_q.size()), 64'd32);
    chk("single_wr_cnt", 64'(wr_addr_q.size()), 64'd32);
    chk("single_cpl_cnt", 64'(cpl_cnt), 64'd32);
    chk("single_first_hs_cycle", 64'(rd_cyc_q[0]), 64'(t0 + 4));
    chk("single_b2b_gap", 64'(rd_cyc_q[1] - rd_cyc_q[0]), 64'd3);
    nbad = 0;
    for (int k = 0; k < 32; k++) begin
      if (rd_addr_q[k] !== 32'h2000_0000 + 32'(k) * 32'h200 || rd_len_q[k] !== 8'd15 ||
          wr_addr_q[k] !== 32'h3000_0000 + 32'(k) * 32'h200 || wr_len_q[k] !== 8'd15 ||
          rd_ch_q[k] !== 2'd0)
        nbad = nbad + 1;
    end
    chk("single_addr_len_steps", 64'(nbad), 64'h0);
    chk("single_done_after_last_cpl", 64'(done_cyc[0] - last_cpl), 64'd1);
    chk("single_busy_cleared", 64'(ch_busy[0]), 64'h0);

    // 4 KB boundary split on the source side
    do_reset();
    set_job(0, 32'h1000_0F00, 32'h2000_0000, 32'd1024);
    pulse_start(4'b0001, t0);
    wait_done(0, 300);
    chk("split_rd_cnt", 64'(rd_addr_q.size()), 64'd3);
    chk("split_lens", 64'({rd_len_q[0], rd_len_q[1], rd_len_q[2]}), 64'h07_0F_07);
    chk("split_rd_addr0", 64'(rd_addr_q[0]), 64'h1000_0F00);
    chk("split_rd_addr1", 64'(rd_addr_q[1]), 64'h1000_1000);
    chk("split_rd_addr2", 64'(rd_addr_q[2]), 64'h1000_1200);
    chk("split_wr_addrs", {wr_addr_q[1], wr_addr_q[2]}, {32'h2000_0100, 32'h2000_0300});
    chk("split_wr_lens", 64'({wr_len_q[0], wr_len_q[1], wr_len_q[2]}), 64'h07_0F_07);

    // Round robin between ch0 and ch2
    do_reset();
    set_job(0, 32'h0000_0000, 32'h0001_0000, 32'd2048);
    set_job(2, 32'h0004_0000, 32'h0005_0000, 32'd2048);
    pulse_start(4'b0101, t0);
    wait_done(0, 300);
    wait_done(2, 300);
    seq_rd = '0;
    seq_wr = '0;
    for (int k = 0; k < 8; k++) begin
      seq_rd = {seq_rd[13:0], rd_ch_q[k]};
      seq_wr = {seq_wr[13:0], wr_ch_q[k]};
    end
    chk("rr_rd_cnt", 64'(rd_ch_q.size()), 64'd8);
    chk("rr_rd_seq", 64'(seq_rd), 64'h2222);
    chk("rr_wr_seq", 64'(seq_wr), 64'h2222);
    chk("rr_ch2_last_addr", 64'(rd_addr_q[7]), 64'h0004_0600);
    chk("rr_both_done", 64'({done_cnt[0][3:0], done_cnt[2][3:0]}), 64'h11);

    // Outstanding limit on ch1, completions withheld
    do_reset();
    cpl_auto = 1'b0;
    set_job(1, 32'h0010_0000, 32'h0020_0000, 32'd8192);
    pulse_start(4'b0010, t0);
    repeat (60) @(negedge ap_clk);
    chk("outst_stall_cnt", 64'(rd_addr_q.size()), 64'd8);
    chk("outst_stall_valid", 64'(rd_cmd_valid), 64'h0);
    chk("outst_still_busy", 64'(ch_busy[1]), 64'h1);
    #3;
    cpl_q.push_back({32'(cyc + 1), 2'd1});
    repeat (30) @(negedge ap_clk);
    chk("outst_one_more", 64'(rd_addr_q.size()), 64'd9);
    chk("outst_ninth_addr", 64'(rd_addr_q[8]), 64'h0010_1000);
    chk("outst_no_done", 64'(done_cnt[1]), 64'h0);

    // Independent handshakes: write side stalled while read side is ready
    do_reset();
    cpl_auto     = 1'b1;
    wr_cmd_ready = 1'b0;
    set_job(3, 32'h0000_8000, 32'h0000_9000, 32'd1024);
    pulse_start(4'b1000, t0);
    wait_rd_valid(20);
    chk("hs_valid_seen", 64'(wr_cmd_valid), 64'h1);
    set_job(3, 32'h0000_A000, 32'h0000_B000, 32'd4096);
    ch_start = 4'b1000;
    @(negedge ap_clk);
    ch_start = '0;
    repeat (4) @(negedge ap_clk);
    chk("hs_rd_once", 64'(rd_addr_q.size()), 64'd1);
    chk("hs_rd_dropped", 64'(rd_cmd_valid), 64'h0);
    chk("hs_wr_held", 64'({wr_cmd_valid, wr_cmd_addr, wr_cmd_len, wr_cmd_ch}),
        64'({1'b1, 32'h0000_9000, 8'd15, 2'd3}));
    wr_cmd_ready = 1'b1;
    wait_done(3, 200);
    chk("hs_done", 64'(done_cnt[3]), 64'h1);
    chk("hs_rd_total", 64'(rd_addr_q.size()), 64'd2);
    chk("hs_second_addr", 64'({rd_addr_q[1], wr_addr_q[1]}), {32'h0000_8200, 32'h0000_9200});
    chk("hs_next_after_wr", 64'(rd_cyc_q[1] - wr_cyc_q[0]), 64'd3);
    chk("hs_payload_stable", 64'(stab_err), 64'h0);

    // Zero length after truncation (16 B < one beat)
    set_job(2, 32'h0000_0100, 32'h0000_0200, 32'd16);
    pulse_start(4'b0100, t0);
    chk("zero_busy_t", 64'({ch_busy[2], ch_done[2]}), 64'b10);
    @(negedge ap_clk);
    chk("zero_done_pulse", 64'({ch_busy[2], ch_done[2]}), 64'b01);
    @(negedge ap_clk);
    chk("zero_done_cleared", 64'(ch_done[2]), 64'h0);
    chk("zero_no_cmds", 64'(rd_addr_q.size()), 64'd2);

    // Reset while a command is waiting in ISSUE
    do_reset();
    rd_cmd_ready = 1'b0;
    wr_cmd_ready = 1'b0;
    set_job(0, 32'h6000_0000, 32'h7000_0000, 32'd4096);
    pulse_start(4'b0001, t0);
    wait_rd_valid(20);
    chk("midrst_in_issue", 64'(rd_cmd_valid), 64'h1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("midrst_busy_done", 64'({ch_busy, ch_done}), 64'h0);
    chk("midrst_valids", 64'({rd_cmd_valid, wr_cmd_valid}), 64'h0);
    chk("midrst_payloads", {rd_cmd_addr, wr_cmd_addr}, 64'h0);
    chk("midrst_len_ch", 64'({rd_cmd_len, rd_cmd_ch, wr_cmd_len, wr_cmd_ch}), 64'h0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("midrst_no_done_pulse", 64'(done_cnt[0]), 64'h0);
    clear_logs();
    rd_cmd_ready = 1'b1;
    wr_cmd_ready = 1'b1;
    #3;
    cpl_q.push_back({32'(cyc + 1), 2'd0});
    repeat (3) @(negedge ap_clk);
    set_job(0, 32'h4000_0000, 32'h5000_0000, 32'd512);
    pulse_start(4'b0001, t0);
    wait_done(0, 200);
    chk("fresh_done", 64'(done_cnt[0]), 64'h1);
    chk("fresh_cmd_cnt", 64'({rd_addr_q.size(), wr_addr_q.size()}), {32'd1, 32'd1});
    chk("fresh_addrs", 64'({rd_addr_q[0], wr_addr_q[0]}), {32'h4000_0000, 32'h5000_0000});
    chk("fresh_latency", 64'(rd_cyc_q[0]), 64'(t0 + 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
